// File: rtl/display_scan_controller_if.sv
// Bundle of the value/control inputs and display outputs of the scan controller.
// carregar is a single-cycle strobe with no backpressure: the controller samples
// valor on every rising clock edge where carregar is high and never stalls it.
interface display_scan_controller_if #(
  parameter int N_DIGITS = 4
);
  logic                    habilita;
  logic [4*N_DIGITS-1:0]   valor;
  logic                    carregar;
  logic                    suprimir_zeros;
  logic [3:0]              digito;
  logic [N_DIGITS-1:0]     anodo;
  logic                    apagar;
  logic                    pendente;
  logic [1:0]              estado;

  // Value-producing side: drives the controls, observes the display
  modport master (
    output habilita, valor, carregar, suprimir_zeros,
    input  digito, anodo, apagar, pendente, estado
  );

  // Scan controller side
  modport slave (
    input  habilita, valor, carregar, suprimir_zeros,
    output digito, anodo, apagar, pendente, estado
  );
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan of N_DIGITS common-anode digits through one shared
// hex decoder. Values are double-buffered and committed only at frame
// boundaries; a one-cycle dark gap precedes every digit to avoid ghosting.
module display_scan_controller #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                   clock,
  input  logic                   reset,
  display_scan_controller_if.slave bus
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    DESLIGADO = 2'd0,
    GUARDA    = 2'd1,
    ATIVO     = 2'd2
  } estado_t;

  estado_t               state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] sombra_q, sombra_d;
  logic [4*N_DIGITS-1:0] exibido_q, exibido_d;
  logic                  pendente_q, pendente_d;
  logic                  supr_q;

  logic tick;
  logic frame_end;
  logic blank;
  logic upper_zero;
  logic [3:0]          digito_s;
  logic [N_DIGITS-1:0] anodo_s;

  assign tick      = (state_q == ATIVO) && (cnt_q == CNT_LAST);
  assign frame_end = tick && (idx_q == IDX_LAST);

  // State, counters and value buffers register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= DESLIGADO;
      cnt_q      <= '0;
      idx_q      <= '0;
      sombra_q   <= '0;
      exibido_q  <= '0;
      pendente_q <= 1'b0;
      supr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sombra_q   <= sombra_d;
      exibido_q  <= exibido_d;
      pendente_q <= pendente_d;
      supr_q     <= bus.suprimir_zeros;
    end
  end

  // Scan FSM next state, refresh counter and digit index; disable wins over all
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      DESLIGADO: begin
        cnt_d = '0;
        idx_d = '0;
        if (bus.habilita) state_d = GUARDA;
      end
      GUARDA: state_d = ATIVO;
      ATIVO: begin
        if (tick) begin
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          state_d = GUARDA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = DESLIGADO;
    endcase
    if (!bus.habilita) begin
      state_d = DESLIGADO;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

  // Shadow load and frame-boundary commit; a load while dark goes straight through
  always_comb begin
    sombra_d   = sombra_q;
    exibido_d  = exibido_q;
    pendente_d = pendente_q;
    if (frame_end && pendente_q) begin
      exibido_d  = sombra_q;
      pendente_d = 1'b0;
    end
    if (bus.carregar) begin
      if (state_q == DESLIGADO) begin
        exibido_d  = bus.valor;
        sombra_d   = bus.valor;
        pendente_d = 1'b0;
      end else begin
        sombra_d   = bus.valor;
        pendente_d = 1'b1;
      end
    end
  end

  // Digit select and leading-zero blanking, decoded from registers only
  always_comb begin
    digito_s   = 4'h0;
    anodo_s    = '1;
    upper_zero = 1'b1;
    blank      = 1'b0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero & (exibido_q[4*i +: 4] == 4'h0);
      if ((idx_q == IDX_W'(i)) && upper_zero) blank = supr_q;
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        digito_s = exibido_q[4*i +: 4];
        if ((state_q == ATIVO) && !blank) anodo_s[i] = 1'b0;
      end
    end
  end

  assign bus.digito   = digito_s;
  assign bus.anodo    = anodo_s;
  assign bus.apagar   = &anodo_s;
  assign bus.pendente = pendente_q;
  assign bus.estado   = state_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller with N_DIGITS=4, REFRESH_DIV=4.
// Reference model tracks the position inside a frame (phase) rather than FSM state.
module tb_display_scan_controller;
  localparam int N     = 4;
  localparam int R     = 4;
  localparam int SLOT  = R + 1;
  localparam int FRAME = N * SLOT;

  // Clock/reset block
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  display_scan_controller_if #(.N_DIGITS(N)) bus ();

  display_scan_controller #(.N_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit          m_on     = 1'b0;
  int          m_phase  = 0;
  logic [15:0] m_disp   = '0;
  logic [15:0] m_shadow = '0;
  bit          m_pend   = 1'b0;
  bit          m_supr   = 1'b0;

  logic [3:0] exp_q[$];
  logic [3:0] exp_an[FRAME];
  logic [3:0] exp_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Model update for one rising edge, using the inputs held across that edge
  task automatic model_edge();
    logic [15:0] old_sh;
    bit          boundary;
    if (reset) begin
      m_on = 0; m_phase = 0; m_disp = '0; m_shadow = '0; m_pend = 0; m_supr = 0;
    end else begin
      old_sh   = m_shadow;
      boundary = m_on && (m_phase == FRAME - 1);
      if (boundary && m_pend) begin
        m_disp = old_sh;
        m_pend = 0;
      end
      if (bus.carregar) begin
        if (!m_on) begin
          m_disp = bus.valor; m_shadow = bus.valor; m_pend = 0;
        end else begin
          m_shadow = bus.valor; m_pend = 1;
        end
      end
      if (!bus.habilita) begin
        m_on = 0; m_phase = 0;
      end else if (!m_on) begin
        m_on = 1; m_phase = 0;
      end else begin
        m_phase = (m_phase + 1) % FRAME;
      end
      m_supr = bus.suprimir_zeros;
    end
  endtask

  task automatic check_model();
    int         d;
    bit         lit;
    logic [3:0] e_an;
    d    = m_on ? (m_phase / SLOT) : 0;
    lit  = m_on && (m_phase % SLOT != 0) && !(m_supr && d > 0 && (m_disp >> (4 * d)) == 16'h0);
    e_an = lit ? ~(4'b0001 << d) : 4'hF;
    check("model_digito",   bus.digito,   m_disp[4*d +: 4]);
    check("model_anodo",    bus.anodo,    e_an);
    check("model_apagar",   bus.apagar,   !lit);
    check("model_pendente", bus.pendente, m_pend);
  endtask

  // Driver: one clock, model update, check away from the edge
  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic goto_phase(input int p);
    for (int k = 0; k < 4 * FRAME && !(m_on && m_phase == p); k++) cycle();
    if (!(m_on && m_phase == p)) begin
      n_checks++;
      $error("FAIL goto_phase: observed phase %0d expected %0d", m_phase, p);
    end
  endtask

  initial begin
    bus.habilita = 0; bus.valor = '0; bus.carregar = 0; bus.suprimir_zeros = 0;
    exp_an = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD,
               4'hF, 4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7};

    // Reset state
    cycle(); cycle();
    check("rst_anodo", bus.anodo, 4'hF);
    check("rst_digito", bus.digito, 4'h0);
    check("rst_apagar", bus.apagar, 1'b1);
    check("rst_pendente", bus.pendente, 1'b0);
    reset = 0;

    // Direct load while dark, then one full frame of 0x1234
    bus.carregar = 1; bus.valor = 16'h1234;
    cycle();
    bus.carregar = 0;
    check("dark_load_pendente", bus.pendente, 1'b0);
    exp_q.push_back(4'h4); exp_q.push_back(4'h3); exp_q.push_back(4'h2); exp_q.push_back(4'h1);
    bus.habilita = 1;
    for (int k = 0; k < FRAME; k++) begin
      cycle();
      check("frame_anodo", bus.anodo, exp_an[k]);
      if (k % SLOT == 1) begin
        exp_val = exp_q.pop_front();
        check("frame_digito", bus.digito, exp_val);
      end
    end
    cycle(); check("frame_len_guard", bus.anodo, 4'hF);
    cycle(); check("frame_len_digit0", bus.anodo, 4'hE);

    // Load 0xABCD while idx=1; commit at next frame
    goto_phase(6);
    bus.carregar = 1; bus.valor = 16'hABCD;
    cycle();
    bus.carregar = 0;
    check("load_pendente", bus.pendente, 1'b1);
    check("load_old_digit1", bus.digito, 4'h3);
    goto_phase(19);
    check("load_pend_at_end", bus.pendente, 1'b1);
    check("load_old_digit3", bus.digito, 4'h1);
    cycle();
    check("commit_pend_drop", bus.pendente, 1'b0);
    cycle(); check("commit_d0", bus.digito, 4'hD);
    goto_phase(6);  check("commit_d1", bus.digito, 4'hC);
    goto_phase(11); check("commit_d2", bus.digito, 4'hB);
    goto_phase(16); check("commit_d3", bus.digito, 4'hA);

    // Load exactly on the boundary tick
    bus.carregar = 1; bus.valor = 16'h1111;
    cycle();
    bus.carregar = 0;
    goto_phase(19);
    bus.carregar = 1; bus.valor = 16'h5678;
    cycle();
    bus.carregar = 0;
    check("edge_load_pendente", bus.pendente, 1'b1);
    cycle(); check("edge_old_shadow_shown", bus.digito, 4'h1);
    goto_phase(19);
    cycle(); check("edge_commit_pend", bus.pendente, 1'b0);
    cycle(); check("edge_new_d0", bus.digito, 4'h8);

    // Leading-zero blanking with 0x0070
    bus.habilita = 0;
    cycle(); check("off_anodo", bus.anodo, 4'hF);
    bus.carregar = 1; bus.valor = 16'h0070; bus.suprimir_zeros = 1;
    cycle();
    bus.carregar = 0; bus.habilita = 1;
    cycle();
    cycle();
    check("lz_d0_anodo", bus.anodo, 4'hE); check("lz_d0_digito", bus.digito, 4'h0);
    goto_phase(6);
    check("lz_d1_anodo", bus.anodo, 4'hD); check("lz_d1_digito", bus.digito, 4'h7);
    goto_phase(11);
    check("lz_d2_anodo", bus.anodo, 4'hF); check("lz_d2_apagar", bus.apagar, 1'b1);
    goto_phase(16);
    check("lz_d3_anodo", bus.anodo, 4'hF);

    // All-zero value: only digit 0 lit, then suppression released
    bus.habilita = 0;
    cycle();
    bus.carregar = 1; bus.valor = 16'h0000;
    cycle();
    bus.carregar = 0; bus.habilita = 1;
    cycle();
    cycle(); check("z_d0_anodo", bus.anodo, 4'hE);
    goto_phase(6);  check("z_d1_anodo", bus.anodo, 4'hF);
    goto_phase(16); check("z_d3_anodo", bus.anodo, 4'hF);
    bus.suprimir_zeros = 0;
    cycle(); check("supr_latency_anodo", bus.anodo, 4'h7);

    // Disable mid-digit at idx=2, then re-enable from digit 0
    bus.carregar = 1; bus.valor = 16'h4321;
    goto_phase(12);
    bus.carregar = 0;
    bus.habilita = 0;
    cycle();
    check("dis_anodo", bus.anodo, 4'hF); check("dis_apagar", bus.apagar, 1'b1);
    bus.habilita = 1;
    cycle(); check("reen_guard", bus.anodo, 4'hF);
    cycle(); check("reen_d0", bus.anodo, 4'hE);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      bus.habilita       = ($urandom_range(0, 19) != 0);
      bus.carregar       = ($urandom_range(0, 9) == 0);
      bus.valor          = 16'($urandom) >> (4 * $urandom_range(0, 3));
      bus.suprimir_zeros = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Reset mid-frame with a pending value
    bus.habilita = 1; bus.carregar = 0; bus.suprimir_zeros = 0;
    cycle(); cycle(); cycle();
    bus.carregar = 1; bus.valor = 16'h9999;
    cycle();
    bus.carregar = 0;
    check("pre_rst_pendente", bus.pendente, 1'b1);
    reset = 1;
    cycle();
    check("mid_rst_anodo", bus.anodo, 4'hF);
    check("mid_rst_digito", bus.digito, 4'h0);
    check("mid_rst_apagar", bus.apagar, 1'b1);
    check("mid_rst_pendente", bus.pendente, 1'b0);
    reset = 0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexing scan controller that shares a single hex-to-7-segment decoder among `N_DIGITS` common-anode digits. It holds the displayed value and walks a digit index at a programmable refresh rate. The current 4-bit nibble goes to the shared decoder, and the matching active-low digit enable is driven. New values are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits. The block sits between the value-producing logic and the decoder/board pins.

## Interface
- `N_DIGITS`, default 4: number of multiplexed digits, range 2..8.
- `REFRESH_DIV`, default 50000: active cycles per digit, range 2..2^20.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `habilita`  in  1  scan enable; low forces the display dark.
- `valor`  in  4*N_DIGITS  value to display; nibble 0 is the least significant digit.
- `carregar`  in  1  one-cycle load strobe; samples `valor` into the shadow register.
- `suprimir_zeros`  in  1  enables leading-zero blanking.
- `digito`  out  4  nibble for the shared decoder, `exibido[4*idx +: 4]`.
- `anodo`  out  N_DIGITS  active-low digit enables; at most one bit is low at any time.
- `apagar`  out  1  high when no digit is lit (decoder output is don't-care).
- `pendente`  out  1  high while the shadow value is waiting for commit.

## Operation
- Registers:
  - `sombra` (shadow), `exibido` (displayed), `pendente`.
  - Refresh counter `cnt`, 0..REFRESH_DIV-1.
  - Digit index `idx`, 0..N_DIGITS-1.
  - `supr_q`, which holds `suprimir_zeros` delayed by one cycle.
  - FSM state.
- FSM states and transitions:
  - DESLIGADO: `cnt`=0 and `idx`=0 are held. `anodo`=all 1, `apagar`=1. Goes to GUARDA when `habilita`=1.
  - GUARDA: one-cycle anti-ghosting gap. `anodo`=all 1, `apagar`=1, and `digito` already shows the new `idx`. Always goes to ATIVO.
  - ATIVO: `anodo[idx]`=0 unless the digit is blanked, and `cnt` increments. A tick occurs when `cnt`=REFRESH_DIV-1. On the tick: `cnt`←0, `idx`←(idx+1) mod N_DIGITS, next state GUARDA.
  - From any state, `habilita`=0 → DESLIGADO on the next cycle. This overrides all other transitions.
- Frame boundary: a tick that occurs while `idx`=N_DIGITS-1.
- Load and commit:
  - `carregar`=1 in GUARDA or ATIVO: `sombra`←`valor`, `pendente`←1.
  - At a frame boundary with `pendente`=1: `exibido`←`sombra` and `pendente`←0, effective from digit 0 of the next frame.
  - `carregar` in the same cycle as a commit: the old `sombra` is committed, the new value is captured into `sombra`, and `pendente` stays 1.
  - `carregar` in DESLIGADO: `exibido`←`valor` and `sombra`←`valor` directly. `pendente` stays 0.
- Leading-zero blanking:
  - Digit i is blanked when `supr_q`=1, i>0, and nibbles i..N_DIGITS-1 of `exibido` are all 0.
  - A blanked digit has `anodo`=all 1 and `apagar`=1.
  - Digit 0 is never blanked.
- `digito` always reflects `exibido` at `idx`, including while blanked.

## Timing
- Reset values:
  - FSM=DESLIGADO, `cnt`=0, `idx`=0.
  - `sombra`=0, `exibido`=0, `pendente`=0, `supr_q`=0.
  - `anodo`=all 1, `digito`=0, `apagar`=1.
- Reset mid-frame: all state returns to the reset values on the next edge, and a pending shadow value is discarded.
- All outputs are decoded from registers only; there is no combinational path from any input to any output.
- Enable latency: `habilita` rising → GUARDA after 1 edge → digit 0 lit after 2 edges.
- Digit slot is REFRESH_DIV+1 cycles (1 GUARDA + REFRESH_DIV lit); frame is N_DIGITS*(REFRESH_DIV+1) cycles.
- Commit latency: the new value is visible from the first cycle of the next frame and never changes within a frame.
- `suprimir_zeros` has a 1-cycle latency through `supr_q`.
- Wrap: `idx` goes N_DIGITS-1 → 0 and `cnt` goes REFRESH_DIV-1 → 0, with no extra cycles.

## Test plan
All scenarios use N_DIGITS=4 and REFRESH_DIV=4.
- Reset, then `habilita`=1 with `exibido`=0x1234:
  - `anodo` sequence 1111(GUARDA), 1110×4, 1111, 1101×4, 1111, 1011×4, 1111, 0111×4.
  - Frame length is 20 cycles.
  - `digito` sequence 4, 3, 2, 1.
- `carregar` with `valor`=0xABCD while `idx`=1:
  - `pendente`=1 until the frame boundary; the remaining digits still show 0x1234.
  - The next frame shows D, C, B, A, and `pendente` drops with the commit.
- `carregar` exactly on the boundary tick:
  - The old shadow is committed and the new value is held.
  - `pendente` stays 1, and the new value appears one frame later.
- `exibido`=0x0070 with `suprimir_zeros`=1:
  - Digits 3 and 2 are blanked (`anodo`=1111, `apagar`=1); digit 1 is lit showing 7 and digit 0 is lit showing 0.
  - With `exibido`=0x0000, only digit 0 is lit.
- `habilita` dropped in ATIVO at `idx`=2: `anodo`=1111 next cycle; re-enable restarts at `idx`=0.
- Synchronous `reset` asserted mid-frame with `pendente`=1: all outputs return to their reset values on the next edge and `pendente`=0.
